// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter.
package period_meter_pkg;

   localparam int PM_MAX_PERIOD_DEFAULT = 800;

   typedef enum logic {PM_IDLE, PM_MEASURE} pm_state_e;

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// Rising-edge detector for pulse_in, with an optional 2-flop synchronizer in front.
// Define PERIOD_METER_SYNC_EN when pulse_in is asynchronous to clk.
module sync_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic pulse_in,
   output logic pulse_edge
);

   logic pulse_s;
   logic pulse_q;
   logic pulse_d;

`ifdef PERIOD_METER_SYNC_EN
   logic sync_1;
   logic sync_2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= pulse_in;
         sync_2 <= sync_1;
      end
   end

   assign pulse_s = sync_2;
`else
   assign pulse_s = pulse_in;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pulse_q <= 1'b0;
         pulse_d <= 1'b0;
      end else begin
         pulse_q <= pulse_s;
         pulse_d <= pulse_q;
      end
   end

   assign pulse_edge = pulse_q & ~pulse_d;

endmodule

// File: rtl/period_meter.sv
// Measures clk-cycle spacing between rising edges of pulse_in; results leave on a valid/rdy register.
// Build option PERIOD_METER_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
//
// state      | meaning
// PM_IDLE    | no reference edge yet; next edge starts a measurement
// PM_MEASURE | counting cycles since the last edge
module period_meter
   import period_meter_pkg::*;
#(
   parameter int MAX_PERIOD = PM_MAX_PERIOD_DEFAULT,
   parameter int PW         = $clog2(MAX_PERIOD + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          pulse_in,
   input  logic          rdy,
   output logic [PW-1:0] period,
   output logic          valid,
   output logic          overflow,
   output logic          missed
);

   localparam logic [PW-1:0] MAX_CNT = PW'(MAX_PERIOD);

   pm_state_e     state_q, state_d;
   logic [PW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] period_q, period_d;
   logic          valid_q, valid_d;
   logic          overflow_q, overflow_d;
   logic          missed_q, missed_d;
   logic          res_vld;
   logic          pulse_edge;

   sync_edge_det u_edge (
      .clk        (clk),
      .reset      (reset),
      .pulse_in   (pulse_in),
      .pulse_edge (pulse_edge)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= PM_IDLE;
         cnt_q      <= '0;
         period_q   <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         missed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         period_q   <= period_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
         missed_q   <= missed_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      res_vld    = 1'b0;
      overflow_d = 1'b0;
      if (!en) begin
         state_d = PM_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            PM_IDLE: begin
               if (pulse_edge) begin
                  state_d = PM_MEASURE;
                  cnt_d   = PW'(1);
               end
            end
            PM_MEASURE: begin
               if (pulse_edge) begin
                  res_vld = 1'b1;
                  cnt_d   = PW'(1);
               end else if (cnt_q < MAX_CNT) begin
                  cnt_d = cnt_q + PW'(1);
               end else begin
                  // no edge in range: the next edge is only a new reference
                  overflow_d = 1'b1;
                  state_d    = PM_IDLE;
                  cnt_d      = '0;
               end
            end
            default: begin
               state_d = PM_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      period_d = period_q;
      valid_d  = valid_q;
      missed_d = 1'b0;
      if (valid_q && rdy) begin
         valid_d = 1'b0;
      end
      if (res_vld) begin
         if (!valid_q || rdy) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
         end else begin
            missed_d = 1'b1;
         end
      end
   end

   assign period   = period_q;
   assign valid    = valid_q;
   assign overflow = overflow_q;
   assign missed   = missed_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: one default instance (MAX_PERIOD=800) and one with MAX_PERIOD=16.
module tb_period_meter;

`ifdef PERIOD_METER_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       pulse_in;
   logic       rdy;
   logic [9:0] period_a;
   logic       valid_a, overflow_a, missed_a;
   logic [4:0] period_b;
   logic       valid_b, overflow_b, missed_b;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int since     = 0;

   always #5 clk = ~clk;

   period_meter dut_a (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .pulse_in (pulse_in),
      .rdy      (rdy),
      .period   (period_a),
      .valid    (valid_a),
      .overflow (overflow_a),
      .missed   (missed_a)
   );

   period_meter #(.MAX_PERIOD(16)) dut_b (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .pulse_in (pulse_in),
      .rdy      (rdy),
      .period   (period_b),
      .valid    (valid_b),
      .overflow (overflow_b),
      .missed   (missed_b)
   );

   typedef struct {
      int gap;
      bit rdy_wait;
      bit rdy_res;
      bit exp_valid;
      int exp_period;
      bit exp_missed;
      bit exp_valid_nx;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      since++;
   endtask

   task automatic do_pulse();
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
      since = 0;
   endtask

   task automatic wait_gap(input int g);
      while (since < g - 1) tick();
   endtask

   initial begin
      int first_ovf;
      int ovf_cycles;

      // rows: gap, rdy while waiting, rdy at result, valid, period, missed, valid next cycle
      vecs[0] = '{0,  1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0};
      vecs[1] = '{10, 1'b1, 1'b1, 1'b1, 10, 1'b0, 1'b0};
      vecs[2] = '{10, 1'b1, 1'b1, 1'b1, 10, 1'b0, 1'b0};
      vecs[3] = '{10, 1'b1, 1'b1, 1'b1, 10, 1'b0, 1'b0};
      vecs[4] = '{10, 1'b1, 1'b1, 1'b1, 10, 1'b0, 1'b0};
      vecs[5] = '{8,  1'b0, 1'b0, 1'b1, 8,  1'b0, 1'b1};
      vecs[6] = '{12, 1'b0, 1'b0, 1'b1, 8,  1'b1, 1'b1};
      vecs[7] = '{7,  1'b0, 1'b1, 1'b1, 7,  1'b0, 1'b0};

      reset    = 1'b0;
      en       = 1'b0;
      pulse_in = 1'b0;
      rdy      = 1'b0;
      tick();
      tick();
      check("reset period", int'(period_a), 0);
      check("reset valid", int'(valid_a), 0);
      check("reset overflow", int'(overflow_a), 0);
      check("reset missed", int'(missed_a), 0);
      reset = 1'b1;
      tick();
      en  = 1'b1;
      rdy = 1'b1;
      tick();

      // steady edges, back-pressure, drop, and accept-with-reload
      for (int i = 0; i < 8; i++) begin
         rdy = vecs[i].rdy_wait;
         if (i > 0) wait_gap(vecs[i].gap);
         do_pulse();
         repeat (LAT - 1) tick();
         rdy = vecs[i].rdy_res;
         tick();
         check($sformatf("row%0d valid", i), int'(valid_a), int'(vecs[i].exp_valid));
         check($sformatf("row%0d period", i), int'(period_a), vecs[i].exp_period);
         check($sformatf("row%0d missed", i), int'(missed_a), int'(vecs[i].exp_missed));
         check($sformatf("row%0d valid_b", i), int'(valid_b), int'(vecs[i].exp_valid));
         check($sformatf("row%0d period_b", i), int'(period_b), vecs[i].exp_period);
         tick();
         check($sformatf("row%0d valid next", i), int'(valid_a), int'(vecs[i].exp_valid_nx));
         check($sformatf("row%0d missed next", i), int'(missed_a), 0);
      end

      // overflow on the MAX_PERIOD=16 instance, gaps 20 then 5
      rdy = 1'b1;
      en  = 1'b0;
      tick();
      en = 1'b1;
      tick();
      do_pulse();
      first_ovf  = -1;
      ovf_cycles = 0;
      while (since < 19) begin
         tick();
         if (overflow_b) begin
            ovf_cycles++;
            if (first_ovf < 0) first_ovf = since;
         end
      end
      check("overflow time", first_ovf, 16 + LAT);
      check("overflow width", ovf_cycles, 1);
      do_pulse();
      repeat (LAT) tick();
      check("after ovf valid_b", int'(valid_b), 0);
      check("gap20 valid_a", int'(valid_a), 1);
      check("gap20 period_a", int'(period_a), 20);
      wait_gap(5);
      do_pulse();
      repeat (LAT) tick();
      check("gap5 valid_b", int'(valid_b), 1);
      check("gap5 period_b", int'(period_b), 5);

      // en low mid-measurement: edges ignored, next edge is a fresh reference
      tick();
      tick();
      en = 1'b0;
      do_pulse();
      repeat (LAT) tick();
      check("en low edge ignored", int'(valid_a), 0);
      tick();
      en = 1'b1;
      tick();
      tick();
      do_pulse();
      repeat (LAT) tick();
      check("en ref edge valid", int'(valid_a), 0);
      rdy = 1'b0;
      wait_gap(6);
      do_pulse();
      repeat (LAT) tick();
      check("en gap6 valid", int'(valid_a), 1);
      check("en gap6 period", int'(period_a), 6);
      tick();
      check("held valid", int'(valid_a), 1);
      rdy = 1'b1;
      tick();
      check("rdy clears valid", int'(valid_a), 0);

      // async reset in the middle of a measurement with a pending result
      rdy = 1'b0;
      wait_gap(6);
      do_pulse();
      repeat (LAT) tick();
      check("pre-reset valid", int'(valid_a), 1);
      tick();
      tick();
      reset = 1'b0;
      #2;
      check("async reset valid", int'(valid_a), 0);
      check("async reset period", int'(period_a), 0);
      check("async reset valid_b", int'(valid_b), 0);
      check("async reset period_b", int'(period_b), 0);
      #2;
      reset = 1'b1;
      rdy   = 1'b1;
      tick();

      // latency: edges 9 apart after reset
      do_pulse();
      repeat (LAT) tick();
      check("post-reset ref valid", int'(valid_a), 0);
      wait_gap(9);
      do_pulse();
      repeat (LAT - 1) tick();
      check("latency early valid", int'(valid_a), 0);
      tick();
      check("latency valid", int'(valid_a), 1);
      check("gap9 period", int'(period_a), 9);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
